// File: rtl/clk_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | clk_pkg: clock-ratio constants shared by pixel divider and DVI   |
// | serializer.  Revision: 1.0                                       |
// +------------------------------------------------------------------+
package clk_pkg;

  localparam int DEFAULT_PXL_DIV = 5;
  // Serial clocks per pixel clock; the serializer loads one symbol per pixel.
  localparam int SER_PER_PXL     = DEFAULT_PXL_DIV;

  function automatic int ceil_half(input int n);
    return (n + 1) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mod_counter: mod-N up counter, async reset to N-1, enable, wrap. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mod_counter #(
  parameter  int N = 5,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  // Any out-of-range value is treated as the last state, so it recovers to 0.
  always_comb begin
    wrap    = (cnt >= LAST);
    cnt_nxt = wrap ? '0 : cnt + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= LAST;
    else if (en)
      cnt <= cnt_nxt;
  end

endmodule
`default_nettype wire

// File: rtl/pxl_clk_div.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pxl_clk_div: integer pixel-clock divider with phase tick/count.  |
// | Optional macro DUTY50_EN: exact 50% duty for odd DIV.            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pxl_clk_div
  import clk_pkg::*;
#(
  parameter  int DIV = DEFAULT_PXL_DIV,
  localparam int CW  = $clog2(DIV)
) (
  input  logic          clki,
  input  logic          rst,
  input  logic          en,
  output logic          clko,
  output logic          tick,
  output logic [CW-1:0] phase
);

  if (DIV < 2 || DIV > 256) begin : g_bad_div
    $error("pxl_clk_div: DIV=%0d outside legal range 2..256", DIV);
  end

`ifdef DUTY50_EN
  localparam bit DUTY50 = (DIV % 2) == 1;
`else
  localparam bit DUTY50 = 1'b0;
`endif

  localparam logic [CW-1:0] H_V = CW'(ceil_half(DIV));
  localparam logic [CW-1:0] L_V = CW'((DIV - 1) / 2);

  logic [CW-1:0] cnt_nxt;
  logic          wrap;

  mod_counter #(.N(DIV)) u_cnt (
    .clk     (clki),
    .rst     (rst),
    .en      (en),
    .cnt     (phase),
    .cnt_nxt (cnt_nxt),
    .wrap    (wrap)
  );

  // The next count is 0 exactly when the counter wraps.
  always_ff @(posedge clki or posedge rst) begin
    if (rst)
      tick <= 1'b0;
    else
      tick <= en & wrap;
  end

  if (DUTY50) begin : g_duty50
    logic pos_q;
    logic neg_q;

    always_ff @(posedge clki or posedge rst) begin
      if (rst)
        pos_q <= 1'b0;
      else if (en)
        pos_q <= (cnt_nxt < L_V);
    end

    // Half-cycle delayed copy stretches the high time by half a period.
    always_ff @(negedge clki or posedge rst) begin
      if (rst)
        neg_q <= 1'b0;
      else if (en)
        neg_q <= pos_q;
    end

    assign clko = pos_q | neg_q;
  end else begin : g_std
    logic clk_q;

    always_ff @(posedge clki or posedge rst) begin
      if (rst)
        clk_q <= 1'b0;
      else if (en)
        clk_q <= (cnt_nxt < H_V);
    end

    assign clko = clk_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_pxl_clk_div.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pxl_clk_div: randomized/directed bench for DIV=5,4,2 dividers.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_pxl_clk_div;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  logic       clko5, tick5;
  logic [2:0] ph5;
  logic       clko4, tick4;
  logic [1:0] ph4;
  logic       clko2, tick2;
  logic [0:0] ph2;

  pxl_clk_div #(.DIV(5)) u_div5 (.clki(clk), .rst(rst), .en(en), .clko(clko5), .tick(tick5), .phase(ph5));
  pxl_clk_div #(.DIV(4)) u_div4 (.clki(clk), .rst(rst), .en(en), .clko(clko4), .tick(tick4), .phase(ph4));
  pxl_clk_div #(.DIV(2)) u_div2 (.clki(clk), .rst(rst), .en(en), .clko(clko2), .tick(tick2), .phase(ph2));

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: k = enabled rising edges since reset.
  int k       = 0;
  bit last_en = 1'b0;

  function automatic int exp_phase(input int div);
    return (k == 0) ? div - 1 : (k - 1) % div;
  endfunction

  function automatic bit exp_clko(input int div);
    if (k == 0) return 1'b0;
    return exp_phase(div) < (div + 1) / 2;
  endfunction

  function automatic bit exp_tick(input int div);
    return last_en && (k > 0) && (exp_phase(div) == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d k=%0d", tag, obs, expv, k);
    end
  endtask

  task automatic check_all();
    chk("phase5", 32'(ph5),   32'(exp_phase(5)));
    chk("clko5",  32'(clko5), 32'(exp_clko(5)));
    chk("tick5",  32'(tick5), 32'(exp_tick(5)));
    chk("phase4", 32'(ph4),   32'(exp_phase(4)));
    chk("clko4",  32'(clko4), 32'(exp_clko(4)));
    chk("tick4",  32'(tick4), 32'(exp_tick(4)));
    chk("phase2", 32'(ph2),   32'(exp_phase(2)));
    chk("clko2",  32'(clko2), 32'(exp_clko(2)));
    chk("tick2",  32'(tick2), 32'(exp_tick(2)));
  endtask

  task automatic step(input bit e);
    en = e;
    @(posedge clk);
    #1;
    if (e) k++;
    last_en = e;
    check_all();
  endtask

  // Called 1 unit after a rising edge; reset stays clear of clock edges.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    k = 0;
    last_en = 1'b0;
    check_all();
    #1;
    rst = 1'b0;
  endtask

  longint rise_t[$];
  longint fall_t[$];
  always @(posedge clko5) rise_t.push_back($time);
  always @(negedge clko5) fall_t.push_back($time);

  int ticks, rises, maxph;
  bit prev_clko;

  initial begin
    #1;
    do_reset();

    // Free run: covers 1,1,1,0,0 / 1,1,0,0 / toggle patterns.
    repeat (12) step(1'b1);

    // Enable gap at phase 2.
    do_reset();
    repeat (3) step(1'b1);
    repeat (3) step(1'b0);
    repeat (4) step(1'b1);

    // Asynchronous reset while clko high at phase 1.
    do_reset();
    repeat (2) step(1'b1);
    #2;
    rst = 1'b1;
    #1;
    k = 0;
    last_en = 1'b0;
    check_all();
    #1;
    rst = 1'b0;
    step(1'b1);

    // Randomized enable.
    repeat (400) step($urandom_range(0, 3) != 0);

    // Edge-to-edge duty measurement on DIV=5.
    do_reset();
    rise_t.delete();
    fall_t.delete();
    en = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    if (rise_t.size() < 2 || fall_t.size() < 1) begin
      vectors++;
      miscompares++;
      $error("FAIL duty_edges observed rises=%0d falls=%0d expected rises>=2 falls>=1",
             rise_t.size(), fall_t.size());
    end else begin
`ifdef DUTY50_EN
      chk("duty_high", 32'(fall_t[0] - rise_t[0]), 32'd25);
      chk("duty_low",  32'(rise_t[1] - fall_t[0]), 32'd25);
`else
      chk("duty_high", 32'(fall_t[0] - rise_t[0]), 32'd30);
      chk("duty_low",  32'(rise_t[1] - fall_t[0]), 32'd20);
`endif
    end

    // Long run: tick and rising-edge counts on DIV=5.
    do_reset();
    ticks = 0;
    rises = 0;
    maxph = 0;
    prev_clko = 1'b0;
    repeat (10000) begin
      step(1'b1);
      if (tick5 === 1'b1) ticks++;
      if (clko5 === 1'b1 && !prev_clko) rises++;
      prev_clko = (clko5 === 1'b1);
      if (int'(ph5) > maxph) maxph = int'(ph5);
    end
    chk("long_ticks", 32'(ticks), 32'd2000);
    chk("long_rises", 32'(rises), 32'd2000);
    chk("long_maxph", 32'(maxph), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
